nec_ir_tx: RTL



---
 rtl/nec_ir_tx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: leader, 32 LSB-first pulse-distance bits, stop burst.
// Bursts are gated by a restartable carrier; LOOP_RXD mirrors receiver polarity.
module nec_ir_tx #(
    parameter int LEAD_MARK    = 450000,
    parameter int LEAD_SPACE   = 225000,
    parameter int BIT_MARK     = 28125,
    parameter int ZERO_SPACE   = 28125,
    parameter int ONE_SPACE    = 84375,
    parameter int CARRIER_HALF = 658
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] ADDR,
    input  logic [7:0] CMD,
    output logic       BUSY,
    output logic       DONE,
    output logic       IRDA_TXD,
    output logic       TX_ENV,
    output logic       LOOP_RXD
);

    localparam int M1      = (LEAD_MARK > LEAD_SPACE) ? LEAD_MARK : LEAD_SPACE;
    localparam int M2      = (BIT_MARK > ZERO_SPACE) ? BIT_MARK : ZERO_SPACE;
    localparam int M3      = (M1 > M2) ? M1 : M2;
    localparam int MAX_DUR = (M3 > ONE_SPACE) ? M3 : ONE_SPACE;
    localparam int CNT_W   = ($clog2(MAX_DUR) > 19) ? $clog2(MAX_DUR) : 19;
    localparam int CAR_W   = ($clog2(CARRIER_HALF) > 1) ? $clog2(CARRIER_HALF) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LMARK  = 3'd1,
        S_LSPACE = 3'd2,
        S_BMARK  = 3'd3,
        S_BSPACE = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, dur_s;
    logic [4:0]         idx_q, idx_d;
    logic [31:0]        frame_q, frame_d;
    logic [CAR_W-1:0]   car_q, car_d;
    logic               txd_q, txd_d;
    logic               done_d;
    logic               burst_d;
    logic               busy_q, done_q, env_q, loop_q;

    function automatic logic is_burst(input state_t s);
        return (s == S_LMARK) || (s == S_BMARK) || (s == S_STOP);
    endfunction

    // Terminal count of the current state (count runs 0 .. duration-1).
    always_comb begin
        dur_s = {CNT_W{1'b0}};
        case (state_q)
            S_LMARK:  dur_s = CNT_W'(LEAD_MARK - 1);
            S_LSPACE: dur_s = CNT_W'(LEAD_SPACE - 1);
            S_BMARK:  dur_s = CNT_W'(BIT_MARK - 1);
            S_STOP:   dur_s = CNT_W'(BIT_MARK - 1);
            S_BSPACE: dur_s = frame_q[idx_q] ? CNT_W'(ONE_SPACE - 1) : CNT_W'(ZERO_SPACE - 1);
            default:  dur_s = {CNT_W{1'b0}};
        endcase
    end

    // Frame sequencing: state, duration counter, bit index and frame latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (START) begin
                    frame_d = {~CMD, CMD, ~ADDR, ADDR};
                    idx_d   = 5'd0;
                    state_d = S_LMARK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LMARK: begin
                if (cnt_q == dur_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_LSPACE;
                end else begin
                    state_d = S_LMARK;
                end
            end
            S_LSPACE, S_BMARK: begin
                if (cnt_q == dur_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = (state_q == S_LSPACE) ? S_BMARK : S_BSPACE;
                end else begin
                    state_d = state_q;
                end
            end
            S_BSPACE: begin
                if (cnt_q == dur_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (idx_q == 5'd31) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_BMARK;
                    end
                end else begin
                    state_d = S_BSPACE;
                end
            end
            S_STOP: begin
                if (cnt_q == dur_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // Carrier: every burst starts high, then toggles each CARRIER_HALF cycles.
    always_comb begin
        burst_d = is_burst(state_d);
        if (!burst_d) begin
            car_d = {CAR_W{1'b0}};
            txd_d = 1'b0;
        end else if (state_d != state_q) begin
            car_d = {CAR_W{1'b0}};
            txd_d = 1'b1;
        end else if (car_q == CAR_W'(CARRIER_HALF - 1)) begin
            car_d = {CAR_W{1'b0}};
            txd_d = ~txd_q;
        end else begin
            car_d = car_q + CAR_W'(1);
            txd_d = txd_q;
        end
    end

    // State and registered outputs, all derived from next-state values.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= 5'd0;
            frame_q <= 32'd0;
            car_q   <= {CAR_W{1'b0}};
            txd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
            loop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            car_q   <= car_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            env_q   <= burst_d;
            loop_q  <= ~burst_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign IRDA_TXD = txd_q;
    assign TX_ENV   = env_q;
    assign LOOP_RXD = loop_q;

endmodule
